sm_step_ctrl: RTL and testbench

- Generates the CPU clock-enable for the board-level top, directly upstream of sm_top's clkEnable input.
- Replaces the raw "SW[9] | ~KEY[1]" combination with two modes: a debounced single-step pulse per button press, or a free-running divided tick.
- Outputs are registered one-cycle enable pulses in the clkIn domain.
- Also drives a visible heartbeat LED and a mode indication.

---
 rtl/sm_step_ctrl.sv | 136 +++++++++++++
 tb/tb_sm_step_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_step_ctrl.sv
// CPU clock-enable generator: debounced single-step pulses or a free-running divided tick.
// Define SM_STEP_CNT_EN to add the stepCount enable-pulse counter output.
module sm_step_ctrl #(
    parameter int unsigned DEBOUNCE_W = 16,
    parameter int unsigned DIV_SHIFT  = 8
`ifdef SM_STEP_CNT_EN
    ,
    parameter int unsigned CNT_W      = 16
`endif
) (
    input  logic       clkIn,
    input  logic       rst_n,
    input  logic       runMode,
    input  logic       stepKey_n,
    input  logic [3:0] clkDevide,
    output logic       clkEnable,
    output logic       tickLed,
    output logic       running
`ifdef SM_STEP_CNT_EN
    ,
    output logic [CNT_W-1:0] stepCount
`endif
);

    // Wide enough that the terminal count at clkDevide=15 cannot overflow
    localparam int unsigned DIV_W = 16 + DIV_SHIFT;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    logic                  r_key_s1, r_key_s2;
    logic                  r_run_s1, r_run_s2;
    logic [DEBOUNCE_W-1:0] r_db_cnt;
    logic                  r_stable, r_stable_d;
    logic                  r_step_req;

    state_t                r_state, w_state_nxt;
    logic [DIV_W-1:0]      r_div, w_div_nxt;
    logic [DIV_W-1:0]      w_term;
    logic                  r_clk_en, w_clk_en_nxt;
    logic                  r_running;
    logic                  r_tick_led;

    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_run_s1   <= 1'b0;
            r_run_s2   <= 1'b0;
            r_db_cnt   <= '0;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_step_req <= 1'b0;
        end else begin
            r_key_s1   <= stepKey_n;
            r_key_s2   <= r_key_s1;
            r_run_s1   <= runMode;
            r_run_s2   <= r_run_s1;
            r_stable_d <= r_stable;
            r_step_req <= r_stable_d & ~r_stable;
            // Level is accepted only after an unbroken run of mismatching samples
            if (r_key_s2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (&r_db_cnt) begin
                r_stable <= r_key_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DEBOUNCE_W'(1);
            end
        end
    end

    assign w_term = (DIV_W'(1) << (32'(clkDevide) + DIV_SHIFT)) - DIV_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_clk_en_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_run_s2) begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = '0;
                end else begin
                    w_clk_en_nxt = r_step_req;
                end
            end
            ST_RUN: begin
                if (!r_run_s2) begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                end else if (r_div >= w_term) begin
                    w_clk_en_nxt = 1'b1;
                    w_div_nxt    = '0;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_clk_en   <= 1'b0;
            r_running  <= 1'b0;
            r_tick_led <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_clk_en   <= w_clk_en_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_tick_led <= r_tick_led ^ r_clk_en;
        end
    end

    assign clkEnable = r_clk_en;
    assign tickLed   = r_tick_led;
    assign running   = r_running;

`ifdef SM_STEP_CNT_EN
    logic [CNT_W-1:0] r_step_cnt;

    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
        end else if (r_clk_en) begin
            r_step_cnt <= r_step_cnt + CNT_W'(1);
        end
    end

    assign stepCount = r_step_cnt;
`endif

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Directed bench for sm_step_ctrl with DEBOUNCE_W=4, DIV_SHIFT=0 (CNT_W=4 when SM_STEP_CNT_EN).
module tb_sm_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       runMode;
    logic       stepKey_n;
    logic [3:0] clkDevide;
    logic       clkEnable;
    logic       tickLed;
    logic       running;
`ifdef SM_STEP_CNT_EN
    logic [3:0] stepCount;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    sm_step_ctrl #(
        .DEBOUNCE_W(4),
        .DIV_SHIFT (0)
`ifdef SM_STEP_CNT_EN
        ,
        .CNT_W     (4)
`endif
    ) u_dut (
        .clkIn    (clk),
        .rst_n    (rst_n),
        .runMode  (runMode),
        .stepKey_n(stepKey_n),
        .clkDevide(clkDevide),
        .clkEnable(clkEnable),
        .tickLed  (tickLed),
        .running  (running)
`ifdef SM_STEP_CNT_EN
        ,
        .stepCount(stepCount)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        stepKey_n = 1'b1;
        runMode   = 1'b0;
        clkDevide = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        stepKey_n = 1'b0;
        runMode   = 1'b1;
        clkDevide = 4'd0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_cnt++;
            if ({clkEnable, tickLed, running} !== 3'b000)
                $display("FAIL reset_outputs cycle %0d: got %b expected 000", i, {clkEnable, tickLed, running});
            else pass_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i <= 3) begin
                check_cnt++;
                if (clkEnable !== 1'b0)
                    $display("FAIL reset_early_tick cycle %0d: got %b expected 0", i, clkEnable);
                else pass_cnt++;
            end
            if (i == 3) begin
                check_cnt++;
                if (running !== 1'b1) $display("FAIL reset_running: got %b expected 1", running);
                else pass_cnt++;
            end
            if (i == 4) begin
                check_cnt++;
                if (clkEnable !== 1'b1) $display("FAIL reset_first_tick: got %b expected 1", clkEnable);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_clean_press();
        int n, at;
        do_reset();
        repeat (2) tick();
        stepKey_n = 1'b0;
        n = 0; at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (clkEnable === 1'b1) begin
                n++;
                if (at < 0) at = i;
            end
        end
        check_cnt++;
        if (n != 1) $display("FAIL press_count: got %0d expected 1", n); else pass_cnt++;
        check_cnt++;
        if (at != 20) $display("FAIL press_latency: got %0d expected 20", at); else pass_cnt++;
        check_cnt++;
        if (tickLed !== 1'b1) $display("FAIL press_tickled: got %b expected 1", tickLed); else pass_cnt++;
        stepKey_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (clkEnable === 1'b1) n++;
        end
        check_cnt++;
        if (n != 0) $display("FAIL release_count: got %0d expected 0", n); else pass_cnt++;
        check_cnt++;
        if (tickLed !== 1'b1) $display("FAIL release_tickled: got %b expected 1", tickLed); else pass_cnt++;
    endtask

    task automatic test_bounce();
        int n, at;
        do_reset();
        repeat (2) tick();
        n = 0;
        for (int i = 0; i < 50; i++) begin
            stepKey_n = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (clkEnable === 1'b1) n++;
        end
        check_cnt++;
        if (n != 0) $display("FAIL bounce_no_pulse: got %0d expected 0", n); else pass_cnt++;
        stepKey_n = 1'b0;
        n = 0; at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (clkEnable === 1'b1) begin
                n++;
                if (at < 0) at = i;
            end
        end
        check_cnt++;
        if (n != 1) $display("FAIL bounce_settle_count: got %0d expected 1", n); else pass_cnt++;
        check_cnt++;
        if (at != 20) $display("FAIL bounce_settle_latency: got %0d expected 20", at); else pass_cnt++;
        stepKey_n = 1'b1;
    endtask

    task automatic test_run_mode();
        int n, err;
        logic exp_en;
        do_reset();
        clkDevide = 4'd3;
        runMode   = 1'b1;
        stepKey_n = 1'b0;
        n = 0; err = 0;
        for (int i = 1; i <= 83; i++) begin
            tick();
            exp_en = (i >= 11) && ((i - 11) % 8 == 0);
            if (clkEnable !== exp_en) err++;
            if (clkEnable === 1'b1) n++;
            if (i == 2) begin
                check_cnt++;
                if (running !== 1'b0) $display("FAIL run_not_yet: got %b expected 0", running);
                else pass_cnt++;
            end
            if (i == 3) begin
                check_cnt++;
                if (running !== 1'b1) $display("FAIL run_running: got %b expected 1", running);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (n != 10) $display("FAIL run_pulse_count: got %0d expected 10", n); else pass_cnt++;
        check_cnt++;
        if (err != 0) $display("FAIL run_pulse_schedule: got %0d bad cycles expected 0", err); else pass_cnt++;
        stepKey_n = 1'b1;
    endtask

    task automatic test_divide_change();
        int n, err;
        logic exp_en;
        do_reset();
        clkDevide = 4'd5;
        runMode   = 1'b1;
        n = 0; err = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            exp_en = (i == 24) || (i == 28) || (i == 32) || (i == 36);
            if (clkEnable !== exp_en) err++;
            if (clkEnable === 1'b1) n++;
            if (i == 23) clkDevide = 4'd2;
            if (i == 36) runMode = 1'b0;
            if (i == 38) begin
                check_cnt++;
                if (running !== 1'b1) $display("FAIL div_still_running: got %b expected 1", running);
                else pass_cnt++;
            end
            if (i == 39) begin
                check_cnt++;
                if (running !== 1'b0) $display("FAIL div_stopped: got %b expected 0", running);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (n != 4) $display("FAIL div_pulse_count: got %0d expected 4", n); else pass_cnt++;
        check_cnt++;
        if (err != 0) $display("FAIL div_pulse_schedule: got %0d bad cycles expected 0", err); else pass_cnt++;
    endtask

`ifdef SM_STEP_CNT_EN
    task automatic test_step_count();
        do_reset();
        for (int p = 0; p < 17; p++) begin
            stepKey_n = 1'b0;
            repeat (25) tick();
            if (p == 0) begin
                check_cnt++;
                if (stepCount !== 4'd1) $display("FAIL count_first: got %0d expected 1", stepCount);
                else pass_cnt++;
            end
            stepKey_n = 1'b1;
            repeat (25) tick();
        end
        check_cnt++;
        if (stepCount !== 4'd1) $display("FAIL count_wrap: got %0d expected 1", stepCount);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_run_mode();
        test_divide_change();
`ifdef SM_STEP_CNT_EN
        test_step_count();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
